// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline hazard controller bus: the pipeline-side request signals and the
// stall / flush / redirect controls returned by the controller.
// master = pipeline datapath side, slave = hazard controller side.
interface pipeline_hazard_controller_if #(
  parameter int RW = 5,
  parameter int AW = 32
);
  // Requests from the pipeline
  logic          ID_EX_MEMread;
  logic [RW-1:0] ID_EX_Rd;
  logic [RW-1:0] IF_ID_RsA;
  logic [RW-1:0] IF_ID_RsB;
  logic [AW-1:0] New_PC_add;
  logic          branch;

  // Controls back to the pipeline
  logic          PC_stall;
  logic          IF_ID_stall;
  logic          IF_ID_flush;
  logic          ID_EX_flush;
  logic [AW-1:0] PC_add;
  logic          PC_redirect;

  modport master (
    output ID_EX_MEMread, ID_EX_Rd, IF_ID_RsA, IF_ID_RsB, New_PC_add, branch,
    input  PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, PC_add, PC_redirect
  );

  modport slave (
    input  ID_EX_MEMread, ID_EX_Rd, IF_ID_RsA, IF_ID_RsB, New_PC_add, branch,
    output PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, PC_add, PC_redirect
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Load-use stall and taken-branch flush controller for a 5-stage pipeline.
// A load whose destination feeds the instruction in decode holds PC and
// IF_ID for LOAD_LAT cycles while bubbling ID_EX; a taken branch redirects
// the PC and bubbles IF_ID for FLUSH_CYC cycles. Branches win over stalls.
// Optional feature: define HAZARD_STATS_EN to add saturating 16-bit
// stall_cnt / flush_cnt statistics outputs.
module pipeline_hazard_controller #(
  parameter int RW        = 5,
  parameter int AW        = 32,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  pipeline_hazard_controller_if.slave bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Counter preload values: the first stall/flush cycle happens in the cycle
  // that detects the event, so the counter covers the remaining N-1 cycles
  // and exits when it reads zero.
  localparam logic [1:0] LOAD_INIT  = (LOAD_LAT  > 1) ? 2'(LOAD_LAT  - 2) : 2'd0;
  localparam logic [1:0] FLUSH_INIT = (FLUSH_CYC > 1) ? 2'(FLUSH_CYC - 2) : 2'd0;

  state_t        state, state_nxt;
  logic [1:0]    cnt, cnt_nxt;
  logic [AW-1:0] pc_hold, pc_hold_nxt;

  logic          hz;
  logic          pc_stall;
  logic          if_id_stall;
  logic          if_id_flush;
  logic          id_ex_flush;
  logic          pc_redirect;
  logic [AW-1:0] pc_add;

  // Load-use hazard: register 0 is hardwired zero and never a real producer.
  assign hz = bus.ID_EX_MEMread
            & (bus.ID_EX_Rd != '0)
            & ((bus.ID_EX_Rd == bus.IF_ID_RsA) | (bus.ID_EX_Rd == bus.IF_ID_RsB));

  // Next-state and output decode; branch first, then the current state.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt   = state;
    cnt_nxt     = cnt;
    pc_hold_nxt = pc_hold;
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pc_redirect = 1'b0;
    pc_add      = pc_hold;

    if (rst) begin
      // Outputs stay quiet for the whole reset window.
      pc_add      = '0;
      state_nxt   = IDLE;
      cnt_nxt     = 2'd0;
      pc_hold_nxt = '0;
    end else if (bus.branch) begin
      // Taken branch: redirect now, bubble both front stages, drop any stall.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      pc_redirect = 1'b1;
      pc_add      = bus.New_PC_add;
      pc_hold_nxt = bus.New_PC_add;
      if (FLUSH_CYC > 1) begin
        cnt_nxt   = FLUSH_INIT;
        state_nxt = FLUSH;
      end else begin
        cnt_nxt   = 2'd0;
        state_nxt = IDLE;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (hz) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            if (LOAD_LAT > 1) begin
              cnt_nxt   = LOAD_INIT;
              state_nxt = STALL;
            end
          end
        end

        STALL: begin
          // Remaining load-latency cycles; hz is not re-evaluated here.
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          if (cnt == 2'd0) state_nxt = IDLE;
          else             cnt_nxt   = cnt - 2'd1;
        end

        FLUSH: begin
          // Wrong-path fetches still arriving: bubble IF_ID only.
          if_id_flush = 1'b1;
          if (cnt == 2'd0) state_nxt = IDLE;
          else             cnt_nxt   = cnt - 2'd1;
        end

        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 2'd0;
        end
      endcase
    end
  end

  // State, counter and redirect-target registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      pc_hold <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pc_hold <= pc_hold_nxt;
    end
  end

  assign bus.PC_stall    = pc_stall;
  assign bus.IF_ID_stall = if_id_stall;
  assign bus.IF_ID_flush = if_id_flush;
  assign bus.ID_EX_flush = id_ex_flush;
  assign bus.PC_redirect = pc_redirect;
  assign bus.PC_add      = pc_add;

`ifdef HAZARD_STATS_EN
  // Saturating event counters: stalled cycles and branch cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (pc_stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (bus.branch && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller. Three instances
// (LOAD_LAT/FLUSH_CYC = 1/1, 3/2, 4/2) share one directed stimulus stream;
// a remaining-cycles model predicts every output each cycle, and directed
// scenarios compare cycle counts and values against hand-computed literals.
module tb_pipeline_hazard_controller;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        memread;
  logic [4:0]  rd, rsa, rsb;
  logic [31:0] new_pc;
  logic        branch;

  // got_flags: {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, PC_redirect}
  logic [4:0]  got_flags [N];
  logic [31:0] got_pc    [N];
`ifdef HAZARD_STATS_EN
  logic [15:0] got_scnt  [N];
  logic [15:0] got_fcnt  [N];
`endif

  int errors = 0;
  int checks = 0;
  bit run    = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LL = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    localparam int FC = (g == 0) ? 1 : 2;

    pipeline_hazard_controller_if #(.RW(5), .AW(32)) bus ();

    assign bus.ID_EX_MEMread = memread;
    assign bus.ID_EX_Rd      = rd;
    assign bus.IF_ID_RsA     = rsa;
    assign bus.IF_ID_RsB     = rsb;
    assign bus.New_PC_add    = new_pc;
    assign bus.branch        = branch;

    pipeline_hazard_controller #(
      .RW(5), .AW(32), .LOAD_LAT(LL), .FLUSH_CYC(FC)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef HAZARD_STATS_EN
      ,
      .stall_cnt (got_scnt[g]),
      .flush_cnt (got_fcnt[g])
`endif
    );

    assign got_flags[g] = {bus.PC_stall, bus.IF_ID_stall, bus.IF_ID_flush,
                           bus.ID_EX_flush, bus.PC_redirect};
    assign got_pc[g]    = bus.PC_add;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks how many stall / flush cycles are still owed, not FSM states.
  int          load_lat  [N] = '{1, 3, 4};
  int          flush_cyc [N] = '{1, 2, 2};
  int          stall_left[N];
  int          flush_left[N];
  logic [31:0] hold      [N];
  int          m_scnt    [N];
  int          m_fcnt    [N];

  always @(negedge clk) begin
    if (run) begin
      logic       hz;
      logic [4:0] ef;
      logic [31:0] epc;
      hz = memread && (rd != 0) && (rd == rsa || rd == rsb);
      for (int i = 0; i < N; i++) begin
        ef  = 5'b00000;
        epc = hold[i];
        if (rst) begin
          epc = 0;
          stall_left[i] = 0;
          flush_left[i] = 0;
        end else if (branch) begin
          ef  = 5'b00111;
          epc = new_pc;
          flush_left[i] = flush_cyc[i] - 1;
          stall_left[i] = 0;
        end else if (flush_left[i] > 0) begin
          ef = 5'b00100;
          flush_left[i]--;
        end else if (stall_left[i] > 0) begin
          ef = 5'b11010;
          stall_left[i]--;
        end else if (hz) begin
          ef = 5'b11010;
          stall_left[i] = load_lat[i] - 1;
        end
        check($sformatf("u%0d_flags", i), 32'(got_flags[i]), 32'(ef));
        check($sformatf("u%0d_pc_add", i), got_pc[i], epc);
`ifdef HAZARD_STATS_EN
        check($sformatf("u%0d_stall_cnt", i), 32'(got_scnt[i]), 32'(m_scnt[i]));
        check($sformatf("u%0d_flush_cnt", i), 32'(got_fcnt[i]), 32'(m_fcnt[i]));
`endif
        // Register effects of this cycle, visible from the next edge.
        if (rst) begin
          hold[i]   = 0;
          m_scnt[i] = 0;
          m_fcnt[i] = 0;
        end else begin
          if (branch) hold[i] = new_pc;
          if (ef[4] && m_scnt[i] < 65535) m_scnt[i]++;
          if (branch && m_fcnt[i] < 65535) m_fcnt[i]++;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int n_stall[N];   // cycles with PC_stall & IF_ID_stall & ID_EX_flush
  int n_iff  [N];   // cycles with IF_ID_flush
  int n_red  [N];   // cycles with PC_redirect

  task automatic clear_inputs();
    memread = 1'b0; rd = 5'd0; rsa = 5'd0; rsb = 5'd0; branch = 1'b0;
  endtask

  task automatic zero_counts();
    for (int i = 0; i < N; i++) begin
      n_stall[i] = 0; n_iff[i] = 0; n_red[i] = 0;
    end
  endtask

  // One cycle: sample at the falling edge, then move to just past the rise.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (got_flags[i][4] && got_flags[i][3] && got_flags[i][1]) n_stall[i]++;
      if (got_flags[i][2]) n_iff[i]++;
      if (got_flags[i][0]) n_red[i]++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic load_use(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    memread = 1'b1; rd = d; rsa = a; rsb = b;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      stall_left[i] = 0; flush_left[i] = 0; hold[i] = 0; m_scnt[i] = 0; m_fcnt[i] = 0;
    end
    rst = 1'b1; new_pc = 32'h0; clear_inputs();
    load_use(5'd7, 5'd7, 5'd1);   // a live hazard must still be masked by reset
    run = 1'b1;

    // Reset state
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_flags_u%0d", i), 32'(got_flags[i]), 32'h0);
      check($sformatf("reset_pc_u%0d", i), got_pc[i], 32'h0);
    end
    @(posedge clk); #1;
    step();
    rst = 1'b0;
    idle(2);

    // Load-use on RsA: 1 / 3 / 4 stalled cycles, then quiet
    zero_counts();
    load_use(5'd7, 5'd7, 5'd1);
    step();
    idle(6);
    check("loaduse_len_lat1", n_stall[0], 1);
    check("loaduse_len_lat3", n_stall[1], 3);
    check("loaduse_len_lat4", n_stall[2], 4);

    // Register 0 never hazards; MEMread=0 never hazards
    zero_counts();
    load_use(5'd0, 5'd0, 5'd0);
    step(); step();
    memread = 1'b0; rd = 5'd4; rsa = 5'd4;
    step();
    idle(2);
    check("r0_no_stall_u0", n_stall[0], 0);
    check("r0_no_stall_u2", n_stall[2], 0);

    // Load-use on RsB
    zero_counts();
    load_use(5'd3, 5'd9, 5'd3);
    step();
    idle(5);
    check("rsb_len_lat3", n_stall[1], 3);

    // Taken branch to DEADBEEF
    zero_counts();
    branch = 1'b1; new_pc = 32'hDEADBEEF;
    @(negedge clk);
    check("br_redirect_u1", 32'(got_flags[1][0]), 32'h1);
    check("br_pc_add_u1", got_pc[1], 32'hDEADBEEF);
    @(posedge clk); #1;
    zero_counts();
    n_iff[1] = 1; n_iff[0] = 1; n_red[1] = 1;  // the branch cycle just checked
    new_pc = 32'h0;
    idle(4);
    check("br_iff_len_fc2", n_iff[1], 2);
    check("br_iff_len_fc1", n_iff[0], 1);
    check("br_redirect_len", n_red[1], 1);
    check("br_pc_hold", got_pc[1], 32'hDEADBEEF);

    // Hazard and branch together: branch wins
    load_use(5'd7, 5'd7, 5'd1);
    branch = 1'b1; new_pc = 32'h0000_0100;
    @(negedge clk);
    check("hzbr_pc_stall", 32'(got_flags[0][4]), 32'h0);
    check("hzbr_flushes", 32'(got_flags[0][2:1]), 32'h3);
    @(posedge clk); #1;
    idle(3);

    // Branch during second STALL cycle of LOAD_LAT=4
    zero_counts();
    load_use(5'd7, 5'd7, 5'd1);
    step();
    clear_inputs();
    branch = 1'b1; new_pc = 32'h0000_0200;
    @(negedge clk);
    check("stall_abort_pc_stall", 32'(got_flags[2][4]), 32'h0);
    check("stall_abort_iff", 32'(got_flags[2][2]), 32'h1);
    @(posedge clk); #1;
    idle(5);
    check("stall_abort_total", n_stall[2], 1);

    // Hazard during FLUSH is ignored; branch in FLUSH restarts the count
    zero_counts();
    branch = 1'b1; new_pc = 32'h0000_0300;
    step();
    branch = 1'b0; load_use(5'd7, 5'd7, 5'd1);
    @(negedge clk);
    check("flush_ignores_hz", 32'(got_flags[1][4]), 32'h0);
    @(posedge clk); #1;
    idle(5);
    zero_counts();
    branch = 1'b1; new_pc = 32'h0000_0400;
    step(); step();
    idle(4);
    check("flush_restart_len", n_iff[1], 3);

    // Reset pulse in the middle of a stall
    load_use(5'd7, 5'd7, 5'd1);
    step();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_flags_u2", 32'(got_flags[2]), 32'h0);
    check("post_rst_pc_u2", got_pc[2], 32'h0);
    @(posedge clk); #1;
    zero_counts();
    idle(4);
    check("post_rst_no_stall", n_stall[2], 0);

`ifdef HAZARD_STATS_EN
    load_use(5'd7, 5'd7, 5'd1);
    step();
    idle(6);
    check("stats_stall_cnt_u2", 32'(got_scnt[2]), 32'd4);
    check("stats_stall_cnt_u0", 32'(got_scnt[0]), 32'd1);
    check("stats_flush_cnt_u2", 32'(got_fcnt[2]), 32'd0);
`endif

    idle(2);
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 The block SHALL have parameter RW, default 5, meaning register-address width.
REQ-002 The block SHALL have parameter AW, default 32, meaning PC width.
REQ-003 The block SHALL have parameter LOAD_LAT, default 1, range 1-4, meaning total stall cycles per load-use hazard.
REQ-004 The block SHALL have parameter FLUSH_CYC, default 1, range 1-4, meaning total IF_ID flush cycles per taken branch.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset; the ports are listed below.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- ID_EX_MEMread  in  1  instruction in EX is a load.
- ID_EX_Rd  in  RW  load destination register.
- IF_ID_RsA / IF_ID_RsB  in  RW  decode-stage source registers.
- New_PC_add  in  AW  branch target.
- branch  in  1  taken branch or jump resolved this cycle.
- PC_stall / IF_ID_stall  out  1  hold PC / hold IF_ID register.
- IF_ID_flush / ID_EX_flush  out  1  bubble IF_ID / bubble ID_EX.
- PC_add  out  AW  redirect target.
- PC_redirect  out  1  PC_add valid this cycle.

Function
REQ-006 The block SHALL define hz = ID_EX_MEMread & (ID_EX_Rd != 0) & (ID_EX_Rd == IF_ID_RsA | ID_EX_Rd == IF_ID_RsB).
REQ-007 The block SHALL implement an FSM with states IDLE, STALL and FLUSH, and a 2-bit down-counter cnt.
REQ-008 In IDLE with hz=1 and branch=0, the block SHALL assert PC_stall, IF_ID_stall and ID_EX_flush in the same cycle.
REQ-009 In the case of REQ-008, if LOAD_LAT>1, the block SHALL load cnt=LOAD_LAT-2 and go to STALL; otherwise it SHALL stay in IDLE.
REQ-010 In STALL, the block SHALL assert PC_stall, IF_ID_stall and ID_EX_flush regardless of hz; when cnt==0 it SHALL go to IDLE, else decrement cnt.
REQ-011 For branch=1 in any state, the block SHALL assert IF_ID_flush, ID_EX_flush and PC_redirect, drive PC_add=New_PC_add, and register New_PC_add into pc_hold, all in the same cycle.
REQ-012 In the case of REQ-011, the block SHALL deassert PC_stall and IF_ID_stall.
REQ-013 In the case of REQ-011, if FLUSH_CYC>1, the block SHALL load cnt=FLUSH_CYC-2 and go to FLUSH; otherwise it SHALL go to IDLE.
REQ-014 In FLUSH with branch=0, the block SHALL assert only IF_ID_flush and SHALL ignore hz; when cnt==0 it SHALL go to IDLE, else decrement cnt.
REQ-015 Branch SHALL take priority over hz; a branch during STALL SHALL abort the stall, and a branch during FLUSH SHALL restart the flush count.
REQ-016 When branch=0, the block SHALL drive PC_add=pc_hold and PC_redirect=0.
REQ-017 The block SHALL never treat register 0 as a hazard source.
REQ-018 In IDLE with hz=0 and branch=0, the block SHALL hold all stall and flush outputs at 0.

Reset
REQ-019 While rst=1, the block SHALL force all 1-bit outputs to 0 and PC_add to 0.
REQ-020 At the first edge with rst=1, the block SHALL set state=IDLE, cnt=0 and pc_hold=0.
REQ-021 A reset asserted mid-STALL or mid-FLUSH SHALL abort it, with no residual stall after rst falls.

Configuration
REQ-022 With macro HAZARD_STATS_EN defined, the block SHALL add outputs stall_cnt[15:0] and flush_cnt[15:0].
REQ-023 stall_cnt SHALL increment on every cycle with PC_stall=1; flush_cnt SHALL increment on every cycle with branch=1.
REQ-024 Both counters SHALL saturate at 16'hFFFF and SHALL be cleared by rst.
REQ-025 Without HAZARD_STATS_EN, the block SHALL have neither these ports nor the counter logic.

Verification
REQ-026 A bench SHALL check: MEMread=1, Rd=7, RsA=7, RsB=1, branch=0, LOAD_LAT=1 -> PC_stall, IF_ID_stall and ID_EX_flush all 1 for exactly 1 cycle.
REQ-027 A bench SHALL check: same stimulus with LOAD_LAT=3, inputs cleared after cycle 1 -> stall outputs 1 for exactly 3 cycles, then 0.
REQ-028 A bench SHALL check: MEMread=1, Rd=0, RsA=0 -> no stall.
REQ-029 A bench SHALL check: branch=1, New_PC_add=32'hDEADBEEF, FLUSH_CYC=2 -> IF_ID_flush 1 for 2 cycles, PC_redirect 1 for 1 cycle, PC_add holds DEADBEEF afterwards.
REQ-030 A bench SHALL check: hz=1 and branch=1 in the same cycle -> PC_stall=0, both flushes 1; branch during 2nd STALL cycle (LOAD_LAT=4) -> stall ends immediately.
REQ-031 A bench SHALL check: rst pulse during STALL -> all outputs 0 in the cycle after reset; with HAZARD_STATS_EN, stall_cnt equals the total number of stalled cycles.
